limn2600_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported Limn2600 SRAM between the CPU instruction-fetch port (read-only) and the data port (read/write). It serialises requests, issues exactly one single-cycle chip-select per access, waits for the SRAM's `rdy` pulse, and captures the data. The SRAM only drives `data_out` during that pulse. The block sits between the CPU core and `limn2600_SRAM`, driving the SRAM's `cs`, `we`, `addr` and `data_in` directly.

---
 rtl/limn2600_mem_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_limn2600_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/limn2600_mem_arbiter.sv
// -----------------------------------------------------------------------------
// limn2600_mem_arbiter
//
// Shares the single-ported Limn2600 SRAM between the CPU instruction-fetch
// port (read-only) and the data port (read/write). Requests are serialised
// through a four-state FSM (IDLE -> ISSUE -> WAIT -> RESP). Each access issues
// one single-cycle chip select, waits for the SRAM rdy pulse, captures the
// data and returns it with a one-cycle ack on the granted port. Conflicts are
// resolved round-robin; the data port counts as "last granted" after reset, so
// the fetch port wins the first conflict.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   i_req/i_addr        fetch request (level) and byte address
//   i_ack/i_rdata       fetch completion pulse and data (0 while i_ack low)
//   d_req/d_we/d_addr   data request (level), write enable, byte address
//   d_wdata             data write value
//   d_ack/d_rdata       data completion pulse and read data (0 for writes)
//   bus_err             accompanies an ack when the access timed out
//   m_cs/m_we           SRAM chip select / write enable (ISSUE cycle only)
//   m_addr/m_wdata      SRAM address / write data (zero outside ISSUE)
//   m_rdy/m_rdata       SRAM ready pulse and read data (only used in WAIT)
//
// Optional feature: define LIMN2600_ARB_TIMEOUT_EN to bound WAIT to
// TIMEOUT_CYCLES cycles, after which the access completes with bus_err=1.
// Without it WAIT holds until m_rdy and bus_err is tied 0.
// -----------------------------------------------------------------------------
module limn2600_mem_arbiter #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req,
    input  logic [31:0]           i_addr,
    output logic                  i_ack,
    output logic [DATA_WIDTH-1:0] i_rdata,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [31:0]           d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,

    output logic                  bus_err,

    output logic                  m_cs,
    output logic                  m_we,
    output logic [31:0]           m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_rdy,
    input  logic [DATA_WIDTH-1:0] m_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic                  last_d_q, last_d_d;   // 1: data port was granted last
    logic                  gnt_d_q, gnt_d_d;     // 1: current grant is the data port
    logic                  we_q, we_d;           // current access is a write
    logic                  m_cs_q, m_cs_d;
    logic                  m_we_q, m_we_d;
    logic [31:0]           m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic                  i_ack_q, i_ack_d;
    logic                  d_ack_q, d_ack_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  grant_d;
    logic [DATA_WIDTH-1:0] cap_data;

`ifdef LIMN2600_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    // Counter value seen in the last permitted WAIT cycle; the increment out
    // of it would reach TIMEOUT_CYCLES.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             bus_err_q, bus_err_d;
`endif

    // Grant the data port if it alone requests, or if both request and the
    // fetch port was served last.
    assign grant_d  = d_req && (!i_req || !last_d_q);
    // Writes return zero regardless of what the SRAM drives.
    assign cap_data = we_q ? '0 : m_rdata;

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        gnt_d_d   = gnt_d_q;
        we_d      = we_q;
        m_cs_d    = 1'b0;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_rdata_d = '0;
        d_rdata_d = '0;
`ifdef LIMN2600_ARB_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        bus_err_d = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    // The m_* registers double as the latched request so the
                    // SRAM sees it during ISSUE without another stage.
                    gnt_d_d   = grant_d;
                    we_d      = grant_d && d_we;
                    m_cs_d    = 1'b1;
                    m_we_d    = grant_d && d_we;
                    m_addr_d  = grant_d ? d_addr : i_addr;
                    m_wdata_d = grant_d ? d_wdata : '0;
                    state_d   = S_ISSUE;
                end
            end

            S_ISSUE: begin
                m_we_d    = 1'b0;
                m_addr_d  = '0;
                m_wdata_d = '0;
`ifdef LIMN2600_ARB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                state_d   = S_WAIT;
            end

            S_WAIT: begin
                if (m_rdy) begin
                    if (gnt_d_q) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = cap_data;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = cap_data;
                    end
                    state_d = S_RESP;
                end
`ifdef LIMN2600_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    d_ack_d   = gnt_d_q;
                    i_ack_d   = !gnt_d_q;
                    bus_err_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end

            S_RESP: begin
                last_d_d = gnt_d_q;
                state_d  = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_d_q  <= 1'b1;
            gnt_d_q   <= 1'b0;
            we_q      <= 1'b0;
            m_cs_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef LIMN2600_ARB_TIMEOUT_EN
            tmo_cnt_q <= '0;
            bus_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            gnt_d_q   <= gnt_d_d;
            we_q      <= we_d;
            m_cs_q    <= m_cs_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef LIMN2600_ARB_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            bus_err_q <= bus_err_d;
`endif
        end
    end

    assign m_cs    = m_cs_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

`ifdef LIMN2600_ARB_TIMEOUT_EN
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_limn2600_mem_arbiter.sv
// -----------------------------------------------------------------------------
// Directed bench for limn2600_mem_arbiter. A small SRAM model answers each
// chip select with a one-cycle rdy in the following cycle, returning
// rd_value ^ address. A monitor sampling 1 time unit after each rising edge
// logs chip selects and acks; directed checks run on falling edges.
// -----------------------------------------------------------------------------
module tb_limn2600_mem_arbiter;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          i_req;
    logic [31:0]   i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [31:0]   d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          bus_err;
    logic          m_cs;
    logic          m_we;
    logic [31:0]   m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_rdy;
    logic [DW-1:0] m_rdata;

    limn2600_mem_arbiter #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_req  (i_req),
        .i_addr (i_addr),
        .i_ack  (i_ack),
        .i_rdata(i_rdata),
        .d_req  (d_req),
        .d_we   (d_we),
        .d_addr (d_addr),
        .d_wdata(d_wdata),
        .d_ack  (d_ack),
        .d_rdata(d_rdata),
        .bus_err(bus_err),
        .m_cs   (m_cs),
        .m_we   (m_we),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_rdy  (m_rdy),
        .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model
    logic [31:0]   rd_value;
    logic          sram_on;
    logic          force_rdy;
    logic          model_rdy;
    logic [DW-1:0] model_rdata;
    logic          cs_s;
    logic [31:0]   addr_s;

    initial begin
        model_rdy   = 1'b0;
        model_rdata = '0;
    end

    always @(posedge clk) begin
        cs_s   = m_cs;
        addr_s = m_addr;
        #1;
        model_rdy   = cs_s && sram_on;
        model_rdata = (cs_s && sram_on) ? (rd_value ^ addr_s) : '0;
    end

    assign m_rdy   = model_rdy | force_rdy;
    assign m_rdata = model_rdy ? model_rdata : (force_rdy ? 32'hBAD0BAD0 : '0);

    // Monitor
    int unsigned   cs_cnt;
    int unsigned   i_cnt;
    int unsigned   d_cnt;
    int unsigned   overlap_cnt;
    logic          ord_q[$];     // 0 = I ack, 1 = D ack
    logic [DW-1:0] dat_q[$];

    initial begin
        cs_cnt      = 0;
        i_cnt       = 0;
        d_cnt       = 0;
        overlap_cnt = 0;
    end

    always @(posedge clk) begin
        #1;
        if (m_cs) cs_cnt++;
        if (i_ack && d_ack) overlap_cnt++;
        if (i_ack) begin
            i_cnt++;
            ord_q.push_back(1'b0);
            dat_q.push_back(i_rdata);
        end
        if (d_ack) begin
            d_cnt++;
            ord_q.push_back(1'b1);
            dat_q.push_back(d_rdata);
        end
    end

    int unsigned n_cmp;
    int unsigned n_mis;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string pfx);
        check_eq({pfx, "_m_cs"},    64'(m_cs),    64'd0);
        check_eq({pfx, "_m_we"},    64'(m_we),    64'd0);
        check_eq({pfx, "_m_addr"},  64'(m_addr),  64'd0);
        check_eq({pfx, "_m_wdata"}, 64'(m_wdata), 64'd0);
        check_eq({pfx, "_i_ack"},   64'(i_ack),   64'd0);
        check_eq({pfx, "_d_ack"},   64'(d_ack),   64'd0);
        check_eq({pfx, "_i_rdata"}, 64'(i_rdata), 64'd0);
        check_eq({pfx, "_d_rdata"}, 64'(d_rdata), 64'd0);
        check_eq({pfx, "_bus_err"}, 64'(bus_err), 64'd0);
    endtask

    int unsigned c0;
    int unsigned a0;
    logic        seen;

    initial begin
        n_cmp     = 0;
        n_mis     = 0;
        rst       = 1'b1;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        rd_value  = '0;
        sram_on   = 1'b1;
        force_rdy = 1'b0;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // I fetch: cs after edge 0, ack after edge 2, gone after edge 3
        rd_value = 32'hDEADBEEF ^ 32'hFFFE0000;
        c0       = cs_cnt;
        i_req    = 1'b1;
        i_addr   = 32'hFFFE0000;
        @(negedge clk);
        check_eq("i_cs_e1",   64'(m_cs),   64'd1);
        check_eq("i_addr_e1", 64'(m_addr), 64'hFFFE0000);
        check_eq("i_we_e1",   64'(m_we),   64'd0);
        @(negedge clk);
        check_eq("i_cs_e2",   64'(m_cs),   64'd0);
        check_eq("i_addr_e2", 64'(m_addr), 64'd0);
        check_eq("i_ack_e2",  64'(i_ack),  64'd0);
        @(negedge clk);
        check_eq("i_ack_e3",   64'(i_ack),   64'd1);
        check_eq("i_rdata_e3", 64'(i_rdata), 64'hDEADBEEF);
        check_eq("i_berr_e3",  64'(bus_err), 64'd0);
        check_eq("i_dack_e3",  64'(d_ack),   64'd0);
        i_req = 1'b0;
        @(negedge clk);
        check_eq("i_ack_off",   64'(i_ack),       64'd0);
        check_eq("i_rdata_off", 64'(i_rdata),     64'd0);
        check_eq("i_cs_pulses", 64'(cs_cnt - c0), 64'd1);

        // D write
        rd_value = 32'hCAFEF00D;
        c0       = cs_cnt;
        d_req    = 1'b1;
        d_we     = 1'b1;
        d_addr   = 32'h00000010;
        d_wdata  = 32'h12345678;
        @(negedge clk);
        check_eq("dw_cs",    64'(m_cs),    64'd1);
        check_eq("dw_we",    64'(m_we),    64'd1);
        check_eq("dw_addr",  64'(m_addr),  64'h10);
        check_eq("dw_wdata", 64'(m_wdata), 64'h12345678);
        @(negedge clk);
        check_eq("dw_we_off",    64'(m_we),    64'd0);
        check_eq("dw_wdata_off", 64'(m_wdata), 64'd0);
        @(negedge clk);
        check_eq("dw_ack",   64'(d_ack),   64'd1);
        check_eq("dw_rdata", 64'(d_rdata), 64'd0);
        check_eq("dw_iack",  64'(i_ack),   64'd0);
        d_req = 1'b0;
        d_we  = 1'b0;
        @(negedge clk);
        check_eq("dw_ack_off",   64'(d_ack),       64'd0);
        check_eq("dw_cs_pulses", 64'(cs_cnt - c0), 64'd1);

        // Both ports held for 16 cycles: I, D, I, D
        ord_q.delete();
        dat_q.delete();
        c0       = i_cnt;
        a0       = d_cnt;
        rd_value = 32'h11110000;
        i_req    = 1'b1;
        i_addr   = 32'h00000100;
        d_req    = 1'b1;
        d_we     = 1'b0;
        d_addr   = 32'h00000200;
        repeat (16) @(negedge clk);
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rr_i_acks", 64'(i_cnt - c0),   64'd2);
        check_eq("rr_d_acks", 64'(d_cnt - a0),   64'd2);
        check_eq("rr_overlap", 64'(overlap_cnt), 64'd0);
        check_eq("rr_n",       64'(ord_q.size()), 64'd4);
        if (ord_q.size() == 4) begin
            check_eq("rr_ord0", 64'(ord_q[0]), 64'd0);
            check_eq("rr_ord1", 64'(ord_q[1]), 64'd1);
            check_eq("rr_ord2", 64'(ord_q[2]), 64'd0);
            check_eq("rr_ord3", 64'(ord_q[3]), 64'd1);
            check_eq("rr_dat0", 64'(dat_q[0]), 64'h11110100);
            check_eq("rr_dat1", 64'(dat_q[1]), 64'h11110200);
            check_eq("rr_dat2", 64'(dat_q[2]), 64'h11110100);
            check_eq("rr_dat3", 64'(dat_q[3]), 64'h11110200);
        end

        // Reset while in WAIT, then a stray rdy
        sram_on = 1'b0;
        a0      = i_cnt + d_cnt;
        i_req   = 1'b1;
        i_addr  = 32'h00000300;
        repeat (2) @(negedge clk);
        rst   = 1'b1;
        i_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("rstw");
        force_rdy = 1'b1;
        @(negedge clk);
        force_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rstw_no_ack", 64'(i_cnt + d_cnt - a0), 64'd0);
        check_idle_outputs("rstw_after");
        sram_on  = 1'b1;
        rd_value = 32'h77770000;
        d_req    = 1'b1;
        d_addr   = 32'h00000040;
        repeat (3) @(negedge clk);
        check_eq("rstw_next_ack",   64'(d_ack),   64'd1);
        check_eq("rstw_next_rdata", 64'(d_rdata), 64'h77770040);
        d_req = 1'b0;
        @(negedge clk);

        // SRAM never answers
        sram_on = 1'b0;
        a0      = i_cnt + d_cnt;
        i_req   = 1'b1;
        i_addr  = 32'h00000500;
`ifdef LIMN2600_ARB_TIMEOUT_EN
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (i_ack) begin
                seen = 1'b1;
                check_eq("tmo_berr",  64'(bus_err), 64'd1);
                check_eq("tmo_rdata", 64'(i_rdata), 64'd0);
            end
        end
        check_eq("tmo_ack_seen", 64'(seen), 64'd1);
        i_req = 1'b0;
        repeat (2) @(negedge clk);
`else
        seen = 1'b0;
        repeat (100) @(negedge clk);
        check_eq("notmo_no_ack", 64'(i_cnt + d_cnt - a0), 64'd0);
        check_eq("notmo_cs",     64'(m_cs),               64'd0);
        rst   = 1'b1;
        i_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
